lsu_ctrl: RTL and testbench

Load/store sequencer between the MEM stage and the single-port word-wide data memory. It takes the decoder's `load_type`/`store_type` codes and the computed address. It runs the memory handshake: a read for loads, read-modify-write for `sb`/`sh` (the memory has no byte enables), and a plain write for `sw`. It returns the sign- or zero-extended load result and stalls the pipeline until the access completes.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_ctrl_if.sv | 30 +++
 rtl/lsu_ctrl_mem_align.sv | 58 +++++
 rtl/lsu_ctrl.sv | 137 +++++++++++++
 tb/tb_lsu_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_ctrl shared types: decoder codes,
// FSM states and request legality check.
package lsu_pkg;

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LH   = 3'd2;
  localparam logic [2:0] LT_LW   = 3'd3;
  localparam logic [2:0] LT_LBU  = 3'd4;
  localparam logic [2:0] LT_LHU  = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } lsu_state_e;

  // Illegal code, load+store mix, or bad alignment.
  function automatic logic bad_req(
    input logic [2:0] lt,
    input logic [1:0] st,
    input logic [1:0] off
  );
    logic both;
    logic half;
    logic word;
    both = (lt != LT_NONE) && (st != ST_NONE);
    half = (lt == LT_LH) || (lt == LT_LHU) ||
           (st == ST_SH);
    word = (lt == LT_LW) || (st == ST_SW);
    return both || (lt >= 3'd6) ||
           (half && off[0]) ||
           (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Word-wide data memory bus between
// lsu_ctrl (master) and the memory (slave).
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/lsu_ctrl_mem_align.sv
// Byte/half lane steering: load extract and
// extend, store merge into the old word.
module mem_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  off,
  input  logic [2:0]  lt,
  input  logic [31:0] wdata,
  input  logic [1:0]  st,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w,
    input logic [1:0]  o,
    input logic [2:0]  t
  );
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {o, 3'b000};
    b  = sh[7:0];
    h  = o[1] ? w[31:16] : w[15:0];
    unique case (t)
      LT_LB:   return {{24{b[7]}}, b};
      LT_LH:   return {{16{h[15]}}, h};
      LT_LBU:  return {24'd0, b};
      LT_LHU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  o,
    input logic [1:0]  t
  );
    logic [31:0] m;
    logic [31:0] v;
    m = 32'h0000_00ff << {o, 3'b000};
    v = {24'd0, wd[7:0]} << {o, 3'b000};
    unique case (t)
      ST_SB:   return (old & ~m) | v;
      ST_SH:   return o[1] ?
                 {wd[15:0], old[15:0]} :
                 {old[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  assign ld_data = ld_ext(rd_word, off, lt);
  assign st_word = st_merge(rd_word, wdata,
                            off, st);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: read, RMW for sb/sh,
// plain write for sw; stalls until done.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [2:0]        load_type,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic [31:0]       rdata_out,
  lsu_ctrl_if.master        mem
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [2:0]        lt_q, lt_d;
  logic [1:0]        st_q, st_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mwd_q, mwd_d;

  logic        req;
  logic        err;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  mem_align u_align (
    .rd_word (mem.mem_rdata),
    .off     (off_q),
    .lt      (lt_q),
    .wdata   (wd_q),
    .st      (st_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  assign req = (load_type != LT_NONE) ||
               (store_type != ST_NONE);
  assign err = bad_req(load_type, store_type,
                       addr[1:0]);

  // Next state, latches and write word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    lt_d    = lt_q;
    st_d    = st_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    mwd_d   = mwd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && req) begin
          addr_d = {addr[ADDR_W-1:2], 2'b00};
          wd_d   = wdata;
          lt_d   = load_type;
          st_d   = store_type;
          off_d  = addr[1:0];
          unique case (1'b1)
            err: state_d = S_ERR;
            (!err && store_type == ST_SW): begin
              state_d = S_WR;
              mwd_d   = wdata;
            end
            default: state_d = S_RD;
          endcase
        end
      end
      S_RD: begin
        if (mem.mem_ready) begin
          if (st_q == ST_NONE) begin
            rdata_d = ld_data;
            state_d = S_DONE;
          end else begin
            mwd_d   = st_word;
            state_d = S_WR;
          end
        end
      end
      S_WR: begin
        if (mem.mem_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      lt_q    <= LT_NONE;
      st_q    <= ST_NONE;
      off_q   <= '0;
      rdata_q <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      lt_q    <= lt_d;
      st_q    <= st_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      mwd_q   <= mwd_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = mwd_q;
  assign mem.mem_re    = (state_q == S_RD);
  assign mem.mem_we    = (state_q == S_WR);

  assign done      = (state_q == S_DONE) ||
                     (state_q == S_ERR);
  assign misalign  = (state_q == S_ERR);
  assign rdata_out = rdata_q;

  assign stall = ((state_q == S_IDLE) &&
                  start && req) ||
                 (state_q == S_RD) ||
                 (state_q == S_WR);

endmodule

// File: tb/tb_lsu_ctrl.sv
// lsu_ctrl bench: directed cases plus random
// ops checked against a byte-level memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        misalign;
  logic [31:0] rdata_out;

  lsu_ctrl_if #(.ADDR_W(32)) mif ();

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .load_type  (load_type),
    .store_type (store_type),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .misalign   (misalign),
    .rdata_out  (rdata_out),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [256];
  logic [31:0] rd_hold;
  logic [31:0] last_wr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int lsize(input logic [2:0] lt);
    case (lt)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int ssize(input logic [1:0] st);
    case (st)
      2'd1:    return 1;
      2'd2:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_err(input logic [2:0] lt,
                                 input logic [1:0] st,
                                 input int off);
    int sz;
    if (lt != 0 && st != 0) return 1'b1;
    if (lt > 5) return 1'b1;
    sz = (lt != 0) ? lsize(lt) : ssize(st);
    return (off % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(
    input logic [2:0] lt, input logic [31:0] w,
    input int off);
    int sz;
    logic [31:0] mask;
    logic [31:0] v;
    sz = lsize(lt);
    mask = (sz == 4) ? 32'hffff_ffff :
           ((32'd1 << (8 * sz)) - 32'd1);
    v = (w >> (8 * off)) & mask;
    if ((lt == 1 || lt == 2) &&
        v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_store(
    input logic [1:0] st, input logic [31:0] old,
    input logic [31:0] wd, input int off);
    logic [7:0] by [4];
    for (int k = 0; k < 4; k++)
      by[k] = 8'(old >> (8 * k));
    for (int k = 0; k < ssize(st); k++)
      by[off + k] = 8'(wd >> (8 * k));
    return {by[3], by[2], by[1], by[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] lt,
                        input logic [1:0] st,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int wmin,
                        input int wmax,
                        output int dc);
    logic [31:0] word, exp_rd, exp_wr;
    logic err, is_ld;
    int idx, off, cyc, wl, nwait, nph;
    bit fin, inph;
    idx = int'(a[9:2]);
    off = int'(a[1:0]);
    word = mem_m[idx];
    err = m_err(lt, st, off);
    is_ld = (lt != 0);
    exp_rd = (err || !is_ld) ? rd_hold :
             m_load(lt, word, off);
    exp_wr = (st == 2'd3) ? wd :
             m_store(st, word, wd, off);
    nph = err ? 0 :
          ((is_ld || st != 3 ? 1 : 0) +
           (st != 0 ? 1 : 0));
    start = 1'b1;
    load_type = lt;
    store_type = st;
    addr = a;
    wdata = wd;
    mif.mem_ready = 1'b0;
    #1;
    chk("stall_c0", stall, 1);
    chk("req_c0", {mif.mem_re, mif.mem_we}, 0);
    tick();
    start = 1'b0;
    load_type = 3'($urandom);
    store_type = 2'($urandom);
    addr = $urandom;
    wdata = $urandom;
    cyc = 1; fin = 0; inph = 0;
    nwait = 0; wl = 0; dc = -1;
    while (!fin && cyc < 60) begin
      if (mif.mem_re || mif.mem_we) begin
        chk("stall_req", stall, 1);
        chk("one_req", mif.mem_re & mif.mem_we, 0);
        chk("mem_addr", mif.mem_addr,
            {a[31:2], 2'b00});
        chk("done_busy", done, 0);
        if (mif.mem_we)
          chk("mem_wdata", mif.mem_wdata, exp_wr);
        if (!inph) begin
          wl = $urandom_range(wmax, wmin);
          inph = 1;
        end
        mif.mem_rdata = mif.mem_re ? word : $urandom;
        if (wl > 0) begin
          mif.mem_ready = 1'b0;
          wl--;
          nwait++;
        end else begin
          mif.mem_ready = 1'b1;
          inph = 0;
          if (mif.mem_we) last_wr = mif.mem_wdata;
        end
      end else begin
        mif.mem_ready = 1'b0;
        chk("done", done, 1);
        chk("misalign", misalign, err);
        chk("stall_done", stall, 0);
        chk("rdata_out", rdata_out, exp_rd);
        dc = cyc;
        fin = 1;
      end
      tick();
      cyc++;
    end
    if (!fin) chk("timeout", 0, 1);
    chk("done_cyc", dc, 1 + nph + nwait);
    chk("done_clr", done, 0);
    chk("rdata_keep", rdata_out, exp_rd);
    if (!err && st != 0) mem_m[idx] = exp_wr;
    rd_hold = exp_rd;
  endtask

  initial begin
    int dc;
    logic [2:0] lt;
    logic [1:0] st;
    for (int i = 0; i < 256; i++) mem_m[i] = $urandom;
    rstn = 1'b0;
    start = 1'b0;
    load_type = 3'd0;
    store_type = 2'd0;
    addr = '0;
    wdata = '0;
    mif.mem_rdata = '0;
    mif.mem_ready = 1'b0;
    rd_hold = '0;
    last_wr = '0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_re", mif.mem_re, 0);
    chk("rst_we", mif.mem_we, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    rstn = 1'b1;
    tick();

    // start with no type: no effect
    start = 1'b1;
    #1 chk("nop_stall", stall, 0);
    tick();
    start = 1'b0;
    chk("nop_re", mif.mem_re, 0);
    chk("nop_done", done, 0);

    mem_m[8'h40] = 32'h80FF1234;
    run_op(3'd1, 2'd0, 32'h103, 0, 0, 0, dc);
    chk("lb_dc", dc, 2);
    chk("lb_val", rdata_out, 32'hFFFFFF80);

    mem_m[8'h40] = 32'h11223344;
    run_op(3'd0, 2'd1, 32'h101, 32'hAB, 0, 0, dc);
    chk("sb_dc", dc, 3);
    chk("sb_wr", last_wr, 32'h1122AB44);

    run_op(3'd0, 2'd3, 32'h200, 32'hDEADBEEF,
           3, 3, dc);
    chk("sw_dc", dc, 5);
    chk("sw_wr", last_wr, 32'hDEADBEEF);

    mem_m[8'h40] = 32'h80010000;
    run_op(3'd5, 2'd0, 32'h102, 0, 0, 0, dc);
    chk("lhu_val", rdata_out, 32'h00008001);
    run_op(3'd2, 2'd0, 32'h102, 0, 0, 0, dc);
    chk("lh_val", rdata_out, 32'hFFFF8001);

    run_op(3'd3, 2'd0, 32'h102, 0, 0, 0, dc);
    chk("lw_mis_dc", dc, 1);
    run_op(3'd0, 2'd2, 32'h001, 5, 0, 0, dc);
    chk("sh_mis_dc", dc, 1);
    run_op(3'd6, 2'd0, 32'h100, 0, 0, 0, dc);
    chk("lt6_dc", dc, 1);
    chk("err_hold", rdata_out, 32'hFFFF8001);
    run_op(3'd3, 2'd3, 32'h100, 0, 0, 0, dc);
    chk("mix_dc", dc, 1);

    // reset during a write wait
    start = 1'b1;
    store_type = 2'd3;
    load_type = 3'd0;
    addr = 32'h40;
    wdata = 32'h12345678;
    mif.mem_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("abort_we", mif.mem_we, 1);
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("abort_we_drop", mif.mem_we, 0);
    chk("abort_stall", stall, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata_out, 0);
    tick();
    tick();
    chk("abort_nodone", done, 0);
    #2 rstn = 1'b1;
    tick();
    chk("abort_nodone2", done, 0);
    rd_hold = '0;
    run_op(3'd3, 2'd0, 32'h0, 0, 0, 0, dc);
    chk("lw0_dc", dc, 2);

    for (int n = 0; n < 40; n++) begin
      do begin
        lt = 3'($urandom);
        st = 2'($urandom);
      end while (lt == 0 && st == 0);
      if ($urandom_range(3, 0) != 0) begin
        if ($urandom_range(1, 0) == 1)
          st = 2'd0;
        else
          lt = 3'd0;
        if (lt == 0 && st == 0) lt = 3'd3;
      end
      run_op(lt, st, {22'd0, 10'($urandom)},
             $urandom, 0, 2, dc);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
